// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: state encoding and widths shared by the data-memory controller files
package dmem_ctrl_pkg;
  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_DONE = 2'd2
  } dmem_state_e;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: word RAM with synchronous write and synchronous registered read
module dmem_array
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] idx,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);
  logic [DATA_W-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_W-1:0] rdata_q;
  // Storage has no reset; only the read register clears.
  always_ff @(posedge clk) begin
    if (en && we) mem_q[idx] <= wdata;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else if (en && !we) rdata_q <= mem_q[idx];
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: wait-state data-memory controller; stalls the CPU until a lw/sw completes
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              stall,
  output logic              misalign
);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
  dmem_state_e             state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    we_q;
  logic [DATA_W-1:0]       wdata_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic                    idle, aligned, accept, reject, en;
  logic                    unused_hi;
  assign idle      = state_q == DMEM_IDLE;
  assign aligned   = addr[1:0] == 2'b00;
  assign accept    = idle && req && aligned;
  assign reject    = idle && req && !aligned;
  assign unused_hi = ^addr[31:ADDR_WIDTH+2];
  always_comb begin
    state_d = DMEM_IDLE;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = (WAIT_CYCLES == 0) ? DMEM_DONE : DMEM_WAIT;
      cnt_d   = CNT_LOAD;
    end else if (state_q == DMEM_WAIT) begin
      state_d = (cnt_q == '0) ? DMEM_DONE : DMEM_WAIT;
      cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CNT_W'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DMEM_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= we;
        wdata_q <= wdata;
        idx_q   <= addr[ADDR_WIDTH+1:2];
      end
    end
  end
  // With zero wait states DONE is entered straight from IDLE, before the latch holds the request.
  assign en = rst_n && state_d == DMEM_DONE;
  dmem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .we    (idle ? we : we_q),
    .idx   (idle ? addr[ADDR_WIDTH+1:2] : idx_q),
    .wdata (idle ? wdata : wdata_q),
    .rdata (rdata)
  );
  assign stall    = rst_n && (accept || state_q == DMEM_WAIT);
  assign ready    = rst_n && (state_q == DMEM_DONE || reject);
  assign misalign = rst_n && reject;
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: table, directed and random checks of dmem_ctrl against a word-array model
module tb_dmem_ctrl;
  localparam int W = 2;
  logic        clk, rst_n;
  logic        a_req, a_we, a_ready, a_stall, a_mis;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        b_req, b_we, b_ready, b_stall, b_mis;
  logic [31:0] b_addr, b_wdata, b_rdata;
  int          checks = 0, errors = 0;
  logic [31:0] mdl [1024];
  logic [31:0] last_rd;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  dmem_ctrl #(.ADDR_WIDTH(10), .WAIT_CYCLES(W)) u_a (
    .clk(clk), .rst_n(rst_n), .req(a_req), .we(a_we), .addr(a_addr), .wdata(a_wdata),
    .rdata(a_rdata), .ready(a_ready), .stall(a_stall), .misalign(a_mis));
  dmem_ctrl #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_b (
    .clk(clk), .rst_n(rst_n), .req(b_req), .we(b_we), .addr(b_addr), .wdata(b_wdata),
    .rdata(b_rdata), .ready(b_ready), .stall(b_stall), .misalign(b_mis));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // One complete access on the WAIT_CYCLES=2 instance, protocol-checked and mirrored in the model.
  task automatic acc_a(input logic w, input logic [31:0] ad, input logic [31:0] wd,
                       output logic [31:0] rd);
    int n, lat, ix;
    ix = int'((ad >> 2) % 1024);
    @(negedge clk);
    a_req = 1'b1; a_we = w; a_addr = ad; a_wdata = wd;
    #2;
    if (ad[1:0] != 2'b00) begin
      chk("mis_ready", 32'(a_ready), 32'd1);
      chk("mis_flag", 32'(a_mis), 32'd1);
      chk("mis_stall", 32'(a_stall), 32'd0);
      chk("mis_rdata", a_rdata, last_rd);
      @(negedge clk);
      a_req = 1'b0;
      rd = last_rd;
    end else begin
      n = 0; lat = 0;
      while (!a_ready && lat < 40) begin
        n += int'(a_stall);
        @(negedge clk);
        a_req = 1'b0;
        #2;
        lat++;
      end
      chk("latency", 32'(lat), 32'(W + 1));
      chk("stall_cycles", 32'(n), 32'(W + 1));
      chk("done_stall", 32'(a_stall), 32'd0);
      chk("done_mis", 32'(a_mis), 32'd0);
      if (w) mdl[ix] = wd;
      else last_rd = mdl[ix];
      chk("rdata", a_rdata, last_rd);
      rd = a_rdata;
      @(negedge clk);
      #2;
      chk("ready_pulse", 32'(a_ready), 32'd0);
      chk("rdata_held", a_rdata, last_rd);
    end
  endtask

  task automatic b_step(input logic r, input logic w, input logic [31:0] ad, input logic [31:0] wd,
                        input logic es, input logic er, input logic crd, input logic [31:0] erd);
    @(negedge clk);
    b_req = r; b_we = w; b_addr = ad; b_wdata = wd;
    #2;
    chk("b_stall", 32'(b_stall), 32'(es));
    chk("b_ready", 32'(b_ready), 32'(er));
    if (crd) chk("b_rdata", b_rdata, erd);
  endtask

  initial begin
    vec_t        tbl [7];
    logic [31:0] rd, old, ad;
    logic        w;
    tbl[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0};
    tbl[1] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
    tbl[2] = '{1'b1, 32'h0000_0004, 32'h4444_4444, 32'h0};
    tbl[3] = '{1'b1, 32'h0000_0006, 32'h0BAD_F00D, 32'h0};
    tbl[4] = '{1'b0, 32'h0000_0004, 32'h0,         32'h4444_4444};
    tbl[5] = '{1'b1, 32'h0000_1000, 32'hA5A5_A5A5, 32'h0};
    tbl[6] = '{1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_A5A5};
    rst_n = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    last_rd = '0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_rdata", a_rdata, 32'h0);
    chk("rst_ready", 32'(a_ready), 32'd0);
    chk("rst_stall", 32'(a_stall), 32'd0);
    chk("rst_mis", 32'(a_mis), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 1024; i++) acc_a(1'b1, 32'(i * 4), $urandom, rd);
    for (int i = 0; i < 7; i++) begin
      acc_a(tbl[i].we, tbl[i].addr, tbl[i].wdata, rd);
      if (!tbl[i].we) chk("tbl_rdata", rd, tbl[i].exp);
    end
    // Reset while a store is waiting: the store must be lost.
    old = mdl[8];
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'h20; a_wdata = 32'h1234_5678;
    #2;
    chk("mid_stall", 32'(a_stall), 32'd1);
    @(negedge clk);
    a_we = 1'b0; a_addr = 32'h6;
    #2;
    chk("mid_wait", 32'(a_stall), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("in_rst_rdata", a_rdata, 32'h0);
    chk("in_rst_ready", 32'(a_ready), 32'd0);
    chk("in_rst_stall", 32'(a_stall), 32'd0);
    chk("in_rst_mis", 32'(a_mis), 32'd0);
    repeat (2) @(negedge clk);
    a_req = 1'b0;
    rst_n = 1'b1;
    last_rd = '0;
    acc_a(1'b0, 32'h20, 32'h0, rd);
    chk("rst_old_value", rd, old);
    // Zero wait states: store two words, then back-to-back loads.
    b_step(1'b1, 1'b1, 32'h0, 32'h0B0B_0000, 1'b1, 1'b0, 1'b0, 32'h0);
    b_step(1'b0, 1'b0, 32'h0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0);
    b_step(1'b1, 1'b1, 32'h4, 32'h0B0B_0004, 1'b1, 1'b0, 1'b0, 32'h0);
    b_step(1'b0, 1'b0, 32'h0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0);
    b_step(1'b1, 1'b0, 32'h0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0);
    b_step(1'b1, 1'b0, 32'h4, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0B0B_0000);
    b_step(1'b1, 1'b0, 32'h4, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0B0B_0000);
    b_step(1'b0, 1'b0, 32'h0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0B0B_0004);
    b_step(1'b0, 1'b0, 32'h0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0B0B_0004);
    b_step(1'b1, 1'b0, 32'h2, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0B0B_0004);
    chk("b_mis", 32'(b_mis), 32'd1);
    b_step(1'b0, 1'b0, 32'h0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 300; i++) begin
      w  = 1'($urandom_range(0, 1));
      ad = $urandom;
      if ($urandom_range(0, 4) != 0) ad[1:0] = 2'b00;
      acc_a(w, ad, $urandom, rd);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Word-addressed data-memory controller sitting directly downstream of the datapath ALU. It consumes the ALU result as a byte address for `lw`/`sw`, performs the access against a local word array after a configurable number of wait states, and holds the CPU with `stall` until the access completes. This prepares the datapath for slower memories without changing the control unit's MemRead/MemWrite encoding.

## Interface
- `ADDR_WIDTH`, 10: word-address bits. Array depth is 2^ADDR_WIDTH words.
- `WAIT_CYCLES`, 2: wait states before the access. Legal range 0..15.

- `clk`  in  1: single clock. All state updates on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  1: access request (MemRead | MemWrite from control).
- `we`  in  1: 1 = store word, 0 = load word. Sampled with `req`.
- `addr`  in  32: byte address, i.e. the ALU `result`.
- `wdata`  in  32: store data (rt register value).
- `rdata`  out  32: load data. Registered and held between loads.
- `ready`  out  1: access complete. Asserted for exactly one cycle per request.
- `stall`  out  1: hold PC and register-file write this cycle.
- `misalign`  out  1: the request was rejected because `addr[1:0] != 0`. Pulses with `ready`.

## Operation
- FSM states:
  - IDLE → WAIT when `req` is high and the address is aligned, with `WAIT_CYCLES > 0`.
  - IDLE → DONE when `req` is high, the address is aligned and `WAIT_CYCLES == 0`.
  - WAIT → DONE when the counter reaches 0.
  - DONE → IDLE unconditionally.
- Accept (IDLE, `req` high, aligned):
  - latch `we`, `wdata` and word index `addr[ADDR_WIDTH+1:2]`;
  - load the counter with `WAIT_CYCLES - 1`.
- WAIT decrements the counter by 1 each cycle.
- Access happens on the edge that enters DONE:
  - store: writes the latched `wdata` to the latched index;
  - load: loads `rdata` from the array.
- Address bits above `ADDR_WIDTH+1` are ignored, so addresses wrap modulo the array size. This is not an error.
- Misaligned request in IDLE:
  - no state change and no array access; `rdata` is unchanged;
  - `ready = 1`, `misalign = 1`, `stall = 0` combinationally in the same cycle.
- `stall` = (IDLE & `req` & aligned) | WAIT. It is 0 in DONE.
- `ready` = DONE | (IDLE & `req` & misaligned).
- A `req` seen in DONE is ignored; the CPU advances at the end of DONE. A `req` in the following IDLE cycle is a new access.
- `req` deasserted during WAIT: the latched access still completes.
- Reset (any time):
  - state IDLE, counter 0, `rdata` = 0, `ready` = 0, `stall` = 0, `misalign` = 0;
  - an in-flight store is discarded and the array is unmodified;
  - array contents are not reset.

## Timing
- Request accepted at cycle T gives DONE and `ready` at cycle T+WAIT_CYCLES+1. The CPU sees `stall` high for WAIT_CYCLES+1 cycles (T..T+WAIT_CYCLES).
- With WAIT_CYCLES = 0, the access takes 1 stall cycle and `ready` is at T+1.
- Load `rdata` is valid from the DONE cycle and held until the next completed load.
- A store is visible to a load accepted in the cycle after DONE.
- Back-to-back requests: minimum issue interval is WAIT_CYCLES+2 cycles, because of the mandatory IDLE cycle.
- The misaligned response has 0-cycle latency (combinational).

## Structure
- State encodings go in the shared control define file, next to the ALUOp codes:
  - `DMEM_IDLE` = 2'd0
  - `DMEM_WAIT` = 2'd1
  - `DMEM_DONE` = 2'd2
- One sub-module, `dmem_array`: a 2^ADDR_WIDTH × 32 RAM with synchronous write and synchronous read, enabled only on the DONE-entry edge.
- The FSM, counter and output decode live in `dmem_ctrl`.

## Test plan
All scenarios use WAIT_CYCLES = 2 unless stated.
- Store then load: store `addr` = 0x0000_0010, `wdata` = 0xDEAD_BEEF; then load 0x10.
  - `stall` high 3 cycles for each access; `ready` is a single pulse; `rdata` = 0xDEADBEEF in the load's DONE cycle.
- Misaligned: `req` = 1, `addr` = 0x0000_0006, `we` = 1.
  - Same cycle: `ready` = 1, `misalign` = 1, `stall` = 0.
  - A subsequent load of 0x4 returns the prior contents.
- Wrap-around: store 0xA5A5_A5A5 at byte address 0x0000_1000 (ADDR_WIDTH = 10); load 0x0.
  - `rdata` = 0xA5A5A5A5.
- Reset mid-store: assert `rst_n` = 0 during WAIT of a store of 0x1234_5678 to 0x20; release; load 0x20.
  - Old value is returned; all outputs read 0 during reset.
- WAIT_CYCLES = 0 back-to-back: loads of 0x0 and 0x4 issued on consecutive IDLE cycles.
  - Each has `stall` for 1 cycle and `ready` 1 cycle later; the issue interval is 2 cycles.
